// File: rtl/alu_seq.sv
// Multi-function ALU with A/G registers, status flags and a shift-add multiplier.
// Single-cycle ops write G one edge after start; multiply writes G WIDTH+1 edges after start.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ain,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] buswires,
    output logic [WIDTH-1:0] aluout,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, MUL} state_t;

    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] g_reg;
    logic [3:0]       flags_reg;
    logic             done_reg;
    logic [WIDTH-1:0] mcand, mplier, acc;
    logic [SHW-1:0]   cnt;

    logic [WIDTH:0]   sum, diff, shl_ext, shr_ext;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res, acc_step, res_val;
    logic             alu_c, alu_v, res_c, res_v;
    logic             write_res, mul_go;

    assign shamt    = buswires[SHW-1:0];
    assign acc_step = mplier[0] ? (acc + mcand) : acc;

    always_comb begin
        sum     = {1'b0, a_reg} + {1'b0, buswires};
        diff    = {1'b0, a_reg} - {1'b0, buswires};
        // Extended by one bit so the last bit shifted out lands in the spare position.
        shl_ext = {1'b0, a_reg} << shamt;
        shr_ext = {a_reg, 1'b0} >> shamt;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            3'b000: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_reg[WIDTH-1] == buswires[WIDTH-1]) &&
                          (sum[WIDTH-1] != a_reg[WIDTH-1]);
            end
            3'b001: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a_reg[WIDTH-1] != buswires[WIDTH-1]) &&
                          (diff[WIDTH-1] != a_reg[WIDTH-1]);
            end
            3'b010: alu_res = a_reg & buswires;
            3'b011: alu_res = a_reg | buswires;
            3'b100: alu_res = a_reg ^ buswires;
            3'b101: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            3'b110: begin
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        write_res  = 1'b0;
        mul_go     = 1'b0;
        res_val    = alu_res;
        res_c      = alu_c;
        res_v      = alu_v;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op == 3'b111) begin
                        mul_go     = 1'b1;
                        state_next = MUL;
                    end else begin
                        write_res = 1'b1;
                    end
                end
            end
            MUL: begin
                // The final step's sum goes straight into G.
                if (cnt == LAST_STEP) begin
                    write_res  = 1'b1;
                    res_val    = acc_step;
                    res_c      = 1'b0;
                    res_v      = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            a_reg     <= '0;
            g_reg     <= '0;
            flags_reg <= '0;
            done_reg  <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            state    <= state_next;
            done_reg <= write_res;
            if (ain) begin
                a_reg <= buswires;
            end
            if (mul_go) begin
                mcand  <= a_reg;
                mplier <= buswires;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == MUL) begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
            if (write_res) begin
                g_reg     <= res_val;
                flags_reg <= {res_val[WIDTH-1], (res_val == '0), res_c, res_v};
            end
        end
    end

    assign aluout = g_reg;
    assign flags  = flags_reg;
    assign busy   = (state == MUL);
    assign done   = done_reg;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-function ALU for the base processor datapath, successor to the add/sub ALU. It keeps the A operand register and the G result register. It adds logic and shift operations, a status-flag register, and a multi-cycle shift-add multiplier with a start/busy/done handshake. The control FSM drives it, and the result is placed on the shared bus through aluout.

## Interface
- WIDTH, 16: datapath width in bits. Must be ≥ 4.
- SHW, $clog2(WIDTH): derived parameter for the shift-amount width. Not overridden.

Ports:
- clock  in  1: rising-edge clock.
- resetn  in  1: reset, asynchronous and active-low.
- ain  in  1: load A from buswires at the clock edge.
- start  in  1: launch the operation selected by op. Operands are A and buswires.
- op  in  3: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr (logical), 111 mul.
- buswires  in  WIDTH: shared bus, the B operand.
- aluout  out  WIDTH: G register.
- flags  out  4: {n, z, c, v}, registered together with G.
- busy  out  1: multiply in progress.
- done  out  1: one-cycle pulse when G and flags hold a new result.

## Operation
- FSM states: IDLE and MUL.
- A register:
  - loads buswires on any edge where ain=1, in either state.
  - A multiply uses an internal copy latched at start, so reloading A during MUL is safe.
- IDLE with start=1 and op≠111:
  - G ← f(A, buswires) truncated to WIDTH bits; flags update at the same edge.
  - The FSM stays in IDLE.
- IDLE with start=1 and op=111:
  - Latch multiplicand ← A, multiplier ← buswires, and clear the accumulator.
  - Go to MUL with a step counter of 0.
- MUL, each cycle:
  - If multiplier bit 0 = 1, accumulator += multiplicand (mod 2^WIDTH).
  - Multiplicand shifts left 1, multiplier shifts right 1, counter increments.
  - After WIDTH steps: G ← accumulator (the low WIDTH bits of A×B), flags update, return to IDLE.
- start while busy: ignored. op and buswires are don't-care during MUL.
- Simultaneous ain and start: the operation uses the A value from before the edge.
- Shifts: the amount is buswires[SHW-1:0]. A shift by 0 leaves A unchanged.
- Flags:
  - n = G[WIDTH-1].
  - z = (G == 0).
  - add: c = carry out; v = signed overflow.
  - sub: c = borrow (A < B unsigned); v = signed overflow.
  - shl/shr: c = the last bit shifted out, or 0 if the amount is 0; v = 0.
  - and/or/xor/mul: c = 0, v = 0.
- G and flags change only on a result-write edge. They hold otherwise.

## Timing
- Reset (resetn=0, asynchronous): A = 0, G = 0, flags = 0000, busy = 0, done = 0, state = IDLE.
- Reset during MUL aborts the multiply immediately. No result is written.
- Single-cycle op: start sampled at edge k. G and flags are valid after edge k. done=1 for the cycle following edge k.
- Multiply: start sampled at edge k.
  - busy=1 from after edge k through after edge k+WIDTH−1.
  - G is written at edge k+WIDTH.
  - busy=0 and done=1 for the cycle after edge k+WIDTH.
  - Total latency is WIDTH+1 edges to done. The next start is accepted on the cycle done is high.
- done never stays high for more than one cycle unless starts are back-to-back.
- Signals are synchronous to clock, with no combinational path from inputs to outputs.

## Test plan
- Reset, then single-cycle ops (WIDTH=16): A=0x7FFF, add B=0x0001.
  - Expect G=0x8000, n=1, z=0, c=0, v=1.
  - done is high one cycle after start.
- Sub with borrow: A=0x0003, sub B=0x0005.
  - Expect G=0xFFFE, n=1, c=1, v=0.
  - Then A=0x1234, sub B=0x1234: expect G=0, z=1, c=0.
- Shifts: A=0x8001, shl by 1 → G=0x0002, c=1. shr by 4 → G=0x0800, c=0. Shift by 0 → G=0x8001, c=0.
- Multiply: A=0x0123, mul B=0x0045.
  - busy stays high 16 cycles, then G=0x4E6F and done pulses once.
  - A start issued mid-multiply is ignored.
  - Reloading A during MUL does not change the result.
- Overflow multiply: 0xFFFF×0xFFFF gives G=0x0001, c=0, v=0.
- Reset mid-multiply: assert resetn=0 at step 7. Expect G=0, busy=0, done=0 immediately.
  - A following add (A=2, B=3) gives G=5 one cycle after start.
